// File: rtl/vpu_exec_unit_if.sv
// Host, SRAM-source and SRAM-destination signals of the VPU execution unit.
// The slave modport is the engine's view; master is the host/SRAM side.
interface vpu_exec_unit_if #(
    parameter int SRAM_BANK_CNT_LG2   = 3,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int STREAM_ID_WIDTH     = 4,
    parameter int OPC_W               = 8
);
    localparam int LOC_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;

    logic [OPC_W-1:0]               req_opcode;
    logic [LOC_W-1:0]               req_src0, req_src1, req_src2, req_dst0;
    logic                           req_valid, req_ready;
    logic [STREAM_ID_WIDTH-1:0]     req_stream_id;
    logic                           resp_valid, resp_ready;
    logic [STREAM_ID_WIDTH-1:0]     resp_stream_id;

    logic                           s0_req, s0_ack, s0_reb, s0_rlast, s0_rvalid;
    logic [SRAM_BANK_CNT_LG2-1:0]   s0_rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] s0_addr;
    logic [SRAM_DATA_WIDTH-1:0]     s0_rdata;
    logic                           s1_req, s1_ack, s1_reb, s1_rlast, s1_rvalid;
    logic [SRAM_BANK_CNT_LG2-1:0]   s1_rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] s1_addr;
    logic [SRAM_DATA_WIDTH-1:0]     s1_rdata;
    logic                           s2_req, s2_ack, s2_reb, s2_rlast, s2_rvalid;
    logic [SRAM_BANK_CNT_LG2-1:0]   s2_rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] s2_addr;
    logic [SRAM_DATA_WIDTH-1:0]     s2_rdata;

    logic                           d_req, d_ack, d_web, d_wlast;
    logic [SRAM_BANK_CNT_LG2-1:0]   d_wid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] d_addr;
    logic [SRAM_DATA_WIDTH-1:0]     d_wdata;

    modport slave (
        input  req_opcode, req_src0, req_src1, req_src2, req_dst0, req_valid, req_stream_id,
        output req_ready,
        output resp_valid, resp_stream_id,
        input  resp_ready,
        output s0_req, s0_reb, s0_rlast, s0_rid, s0_addr,
        input  s0_ack, s0_rvalid, s0_rdata,
        output s1_req, s1_reb, s1_rlast, s1_rid, s1_addr,
        input  s1_ack, s1_rvalid, s1_rdata,
        output s2_req, s2_reb, s2_rlast, s2_rid, s2_addr,
        input  s2_ack, s2_rvalid, s2_rdata,
        output d_req, d_web, d_wlast, d_wid, d_addr, d_wdata,
        input  d_ack
    );

    modport master (
        output req_opcode, req_src0, req_src1, req_src2, req_dst0, req_valid, req_stream_id,
        input  req_ready,
        input  resp_valid, resp_stream_id,
        output resp_ready,
        input  s0_req, s0_reb, s0_rlast, s0_rid, s0_addr,
        output s0_ack, s0_rvalid, s0_rdata,
        input  s1_req, s1_reb, s1_rlast, s1_rid, s1_addr,
        output s1_ack, s1_rvalid, s1_rdata,
        input  s2_req, s2_reb, s2_rlast, s2_rid, s2_addr,
        output s2_ack, s2_rvalid, s2_rdata,
        input  d_req, d_web, d_wlast, d_wid, d_addr, d_wdata,
        output d_ack
    );
endinterface

// File: rtl/vpu_exec_unit.sv
// Single-issue VPU execution engine: fetch up to three 16x32-bit operands,
// compute a lane-wise result, write it back, then report completion.
module vpu_exec_unit #(
    parameter int SRAM_BANK_CNT_LG2   = 3,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int STREAM_ID_WIDTH     = 4,
    parameter int OPC_W               = 8
) (
    input logic clk,
    input logic rst_n,
    vpu_exec_unit_if.slave bus
);
    localparam int DEPTH = SRAM_BANK_DEPTH_LG2;
    localparam int LOC_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
    localparam int NLANE = SRAM_DATA_WIDTH / 32;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'('h01);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'('h02);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'('h03);
    localparam logic [OPC_W-1:0] OP_MAX  = OPC_W'('h04);
    localparam logic [OPC_W-1:0] OP_ADD3 = OPC_W'('h05);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_RESP} state_t;

    state_t                       state, state_nxt;
    logic [OPC_W-1:0]             opc_q;
    logic [LOC_W-1:0]             src_q [3];
    logic [LOC_W-1:0]             dst_q;
    logic [STREAM_ID_WIDTH-1:0]   sid_q;
    logic [2:0]                   rd_req_q, got_q, need, ack, rvalid;
    logic [SRAM_DATA_WIDTH-1:0]   opnd_q [3];
    logic [SRAM_DATA_WIDTH-1:0]   rdata [3];
    logic [SRAM_DATA_WIDTH-1:0]   result_q, result_nxt;
    logic                         all_got, req_rdy, wr_req, resp_vld;

    // Which source ports an opcode reads; anything unrecognised behaves as COPY.
    function automatic logic [2:0] src_mask(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_MUL, OP_MAX: return 3'b011;
            OP_ADD3:                        return 3'b111;
            default:                        return 3'b001;
        endcase
    endfunction

    function automatic logic [31:0] lane_alu(input logic [OPC_W-1:0] opc,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b,
                                             input logic signed [31:0] c);
        case (opc)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_MAX:  return (a > b) ? a : b;
            OP_ADD3: return a + b + c;
            default: return a;
        endcase
    endfunction

    assign ack    = {bus.s2_ack, bus.s1_ack, bus.s0_ack};
    assign rvalid = {bus.s2_rvalid, bus.s1_rvalid, bus.s0_rvalid};
    assign rdata[0] = bus.s0_rdata;
    assign rdata[1] = bus.s1_rdata;
    assign rdata[2] = bus.s2_rdata;

    assign need    = src_mask(opc_q);
    // Counts an operand arriving this cycle so READ can exit without an idle cycle.
    assign all_got = (((got_q | rvalid) & need) == need);

    always_comb begin
        result_nxt = '0;
        for (int i = 0; i < NLANE; i++)
            result_nxt[i*32 +: 32] = lane_alu(opc_q, opnd_q[0][i*32 +: 32],
                                              opnd_q[1][i*32 +: 32], opnd_q[2][i*32 +: 32]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        wr_req    = 1'b0;
        resp_vld  = 1'b0;
        case (state)
            S_IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_valid) state_nxt = S_READ;
            end
            S_READ:  if (all_got) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                wr_req = 1'b1;
                if (bus.d_ack) state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_vld = 1'b1;
                if (bus.resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q    <= '0;
            dst_q    <= '0;
            sid_q    <= '0;
            rd_req_q <= '0;
            got_q    <= '0;
            result_q <= '0;
            for (int n = 0; n < 3; n++) begin
                src_q[n]  <= '0;
                opnd_q[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    opc_q    <= bus.req_opcode;
                    src_q[0] <= bus.req_src0;
                    src_q[1] <= bus.req_src1;
                    src_q[2] <= bus.req_src2;
                    dst_q    <= bus.req_dst0;
                    sid_q    <= bus.req_stream_id;
                    rd_req_q <= src_mask(bus.req_opcode);
                    got_q    <= '0;
                end
                S_READ: begin
                    for (int n = 0; n < 3; n++) begin
                        if (rd_req_q[n] && ack[n]) rd_req_q[n] <= 1'b0;
                        if (need[n] && !got_q[n] && rvalid[n]) begin
                            opnd_q[n] <= rdata[n];
                            got_q[n]  <= 1'b1;
                        end
                    end
                    if (all_got) rd_req_q <= '0;
                end
                S_EXEC:  result_q <= result_nxt;
                default: ;
            endcase
        end
    end

    assign bus.req_ready      = req_rdy;
    assign bus.resp_valid     = resp_vld;
    assign bus.resp_stream_id = resp_vld ? sid_q : '0;

    assign bus.s0_req   = rd_req_q[0];
    assign bus.s0_reb   = ~rd_req_q[0];
    assign bus.s0_rlast = rd_req_q[0];
    assign bus.s0_rid   = rd_req_q[0] ? src_q[0][LOC_W-1:DEPTH] : '0;
    assign bus.s0_addr  = rd_req_q[0] ? src_q[0][DEPTH-1:0] : '0;
    assign bus.s1_req   = rd_req_q[1];
    assign bus.s1_reb   = ~rd_req_q[1];
    assign bus.s1_rlast = rd_req_q[1];
    assign bus.s1_rid   = rd_req_q[1] ? src_q[1][LOC_W-1:DEPTH] : '0;
    assign bus.s1_addr  = rd_req_q[1] ? src_q[1][DEPTH-1:0] : '0;
    assign bus.s2_req   = rd_req_q[2];
    assign bus.s2_reb   = ~rd_req_q[2];
    assign bus.s2_rlast = rd_req_q[2];
    assign bus.s2_rid   = rd_req_q[2] ? src_q[2][LOC_W-1:DEPTH] : '0;
    assign bus.s2_addr  = rd_req_q[2] ? src_q[2][DEPTH-1:0] : '0;

    assign bus.d_req   = wr_req;
    assign bus.d_web   = ~wr_req;
    assign bus.d_wlast = wr_req;
    assign bus.d_wid   = wr_req ? dst_q[LOC_W-1:DEPTH] : '0;
    assign bus.d_addr  = wr_req ? dst_q[DEPTH-1:0] : '0;
    assign bus.d_wdata = wr_req ? result_q : '0;
endmodule

// File: tb/tb_vpu_exec_unit.sv
// Directed bench for vpu_exec_unit: behavioural host and SRAM ports, hand-computed results.
module tb_vpu_exec_unit;
    localparam int BK = 3, DP = 10, DW = 512, SW = 4, OW = 8, LW = BK + DP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_exec_unit_if #(.SRAM_BANK_CNT_LG2(BK), .SRAM_BANK_DEPTH_LG2(DP), .SRAM_DATA_WIDTH(DW),
                       .STREAM_ID_WIDTH(SW), .OPC_W(OW)) bus ();

    vpu_exec_unit #(.SRAM_BANK_CNT_LG2(BK), .SRAM_BANK_DEPTH_LG2(DP), .SRAM_DATA_WIDTH(DW),
                    .STREAM_ID_WIDTH(SW), .OPC_W(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]    s_req, s_reb, s_rlast;
    logic [LW-1:0] s_loc [3];
    assign s_req   = {bus.s2_req, bus.s1_req, bus.s0_req};
    assign s_reb   = {bus.s2_reb, bus.s1_reb, bus.s0_reb};
    assign s_rlast = {bus.s2_rlast, bus.s1_rlast, bus.s0_rlast};
    assign s_loc[0] = {bus.s0_rid, bus.s0_addr};
    assign s_loc[1] = {bus.s1_rid, bus.s1_addr};
    assign s_loc[2] = {bus.s2_rid, bus.s2_addr};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int n, input logic a, input logic v, input logic [DW-1:0] d);
        case (n)
            0: begin bus.s0_ack = a; bus.s0_rvalid = v; bus.s0_rdata = d; end
            1: begin bus.s1_ack = a; bus.s1_rvalid = v; bus.s1_rdata = d; end
            default: begin bus.s2_ack = a; bus.s2_rvalid = v; bus.s2_rdata = d; end
        endcase
    endtask

    task automatic clear_inputs();
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_stream_id = '0;
        bus.req_src0 = '0; bus.req_src1 = '0; bus.req_src2 = '0; bus.req_dst0 = '0;
        bus.resp_ready = 1'b0; bus.d_ack = 1'b0;
        for (int n = 0; n < 3; n++) set_port(n, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".req_ready"}, bus.req_ready, 1'b1);
        check({nm, ".s_req"}, s_req, 3'b000);
        check({nm, ".s_reb_rlast"}, {s_reb, s_rlast}, 6'b111_000);
        check({nm, ".s_loc"}, {s_loc[2], s_loc[1], s_loc[0]}, '0);
        check({nm, ".d_ctl"}, {bus.d_req, bus.d_web, bus.d_wlast}, 3'b010);
        check({nm, ".d_wdata"}, bus.d_wdata, '0);
        check({nm, ".resp"}, {bus.resp_valid, bus.resp_stream_id}, '0);
    endtask

    // Issues one instruction and plays host + SRAM until the completion handshake.
    task automatic run_instr(input string nm, input logic [OW-1:0] opc,
                             input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                             input logic [LW-1:0] l2, input logic [LW-1:0] ld,
                             input logic [SW-1:0] sid,
                             input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                             input int rd0, input int rd1, input int rd2,
                             input int ack_dly, input int d_dly, input int r_dly, input bit noise,
                             input logic [31:0] exp_lane, input logic [2:0] exp_use,
                             input int abort_at);
        logic [LW-1:0] loc [3];
        logic [31:0]   val [3];
        int            rd [3], age [3], rlen [3];
        bit            seen [3];
        logic [2:0]    used;
        logic [DW-1:0] w0;
        logic [LW-1:0] wloc;
        logic [SW-1:0] rsid;
        int            dcnt, rcnt, writes, cyc;
        bit            done, busy_bad, hold_bad, addr_bad, prev_d;
        loc[0] = l0; loc[1] = l1; loc[2] = l2;
        val[0] = v0; val[1] = v1; val[2] = v2;
        rd[0] = rd0; rd[1] = rd1; rd[2] = rd2;
        for (int n = 0; n < 3; n++) begin age[n] = 0; rlen[n] = 0; seen[n] = 1'b0; end
        used = '0; w0 = '0; wloc = '0; rsid = '0;
        dcnt = 0; rcnt = 0; writes = 0; cyc = 0;
        done = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0; addr_bad = 1'b0; prev_d = 1'b0;

        @(negedge clk);
        check({nm, ".ready_idle"}, bus.req_ready, 1'b1);
        bus.req_opcode = opc; bus.req_src0 = l0; bus.req_src1 = l1; bus.req_src2 = l2;
        bus.req_dst0 = ld; bus.req_stream_id = sid; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;

        while (!done && cyc < 300) begin
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs({nm, ".abort"});
                clear_inputs();
                @(negedge clk);
                check({nm, ".abort_no_resp"}, {bus.resp_valid, bus.req_ready}, 2'b01);
                #2 rst_n = 1'b1;
                return;
            end
            if (bus.req_ready) busy_bad = 1'b1;
            for (int n = 0; n < 3; n++) begin
                logic a, v;
                logic [DW-1:0] d;
                a = 1'b0; v = 1'b0; d = '0;
                if (s_req[n]) begin
                    used[n] = 1'b1;
                    if (s_loc[n] !== loc[n] || s_reb[n] !== 1'b0 || s_rlast[n] !== 1'b1)
                        addr_bad = 1'b1;
                    if (!seen[n]) begin seen[n] = 1'b1; age[n] = 0; end
                    a = (rlen[n] >= ack_dly);
                    rlen[n]++;
                end
                if (seen[n]) begin
                    v = (age[n] == rd[n]) || (age[n] == rd[n] + 1);
                    d = (age[n] == rd[n]) ? {16{val[n]}} : {16{32'hDEAD_BEEF}};
                    age[n]++;
                end else if (noise) begin
                    a = 1'b1; v = 1'b1; d = {16{32'hBAD0_0BAD}};
                end
                set_port(n, a, v, d);
            end
            if (bus.d_req) begin
                if (!prev_d) begin
                    writes++;
                    w0 = bus.d_wdata;
                    wloc = {bus.d_wid, bus.d_addr};
                end else if (bus.d_wdata !== w0 || {bus.d_wid, bus.d_addr} !== wloc) begin
                    hold_bad = 1'b1;
                end
                if (bus.d_web !== 1'b0 || bus.d_wlast !== 1'b1) hold_bad = 1'b1;
                bus.d_ack = (dcnt >= d_dly);
                dcnt++;
            end else begin
                bus.d_ack = 1'b0;
                dcnt = 0;
            end
            prev_d = bus.d_req;
            if (bus.resp_valid) begin
                if (rcnt == 0) rsid = bus.resp_stream_id;
                else if (bus.resp_stream_id !== rsid) hold_bad = 1'b1;
                bus.resp_ready = (rcnt >= r_dly);
                done = bus.resp_ready;
                rcnt++;
            end else begin
                bus.resp_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        clear_inputs();

        check({nm, ".completed"}, done, 1'b1);
        check({nm, ".wdata"}, w0, {16{exp_lane}});
        check({nm, ".wloc"}, wloc, ld);
        check({nm, ".writes"}, writes, 1);
        check({nm, ".resp_sid"}, rsid, sid);
        check({nm, ".ports_used"}, used, exp_use);
        check({nm, ".rd_addr_ctl"}, addr_bad, 1'b0);
        check({nm, ".held_stable"}, hold_bad, 1'b0);
        check({nm, ".busy_not_ready"}, busy_bad, 1'b0);
        check({nm, ".ready_after"}, {bus.req_ready, bus.resp_valid}, 2'b10);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        //        name    opc     src0         src1         src2         dst0           sid
        run_instr("add",  8'h01, {3'd1,10'd5}, {3'd2,10'd6}, {3'd3,10'd7}, {3'd5,10'd100}, 4'd3,
                  32'd1, 32'd2, 32'd0, 1, 2, 0, 0, 0, 0, 1'b0, 32'd3, 3'b011, 0);
        run_instr("sub",  8'h02, {3'd0,10'd1}, {3'd7,10'd1023}, {3'd0,10'd0}, {3'd4,10'd9}, 4'd5,
                  32'd0, 32'd1, 32'd0, 0, 3, 0, 1, 0, 0, 1'b0, 32'hFFFF_FFFF, 3'b011, 0);
        run_instr("max_neg", 8'h04, {3'd1,10'd2}, {3'd2,10'd3}, {3'd0,10'd0}, {3'd6,10'd11}, 4'd1,
                  32'hFFFF_FFFF, 32'd5, 32'd0, 2, 0, 0, 0, 0, 0, 1'b0, 32'd5, 3'b011, 0);
        run_instr("max_pos", 8'h04, {3'd3,10'd4}, {3'd4,10'd5}, {3'd0,10'd0}, {3'd7,10'd12}, 4'd2,
                  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 0, 0, 0, 0, 0, 0, 1'b0,
                  32'h7FFF_FFFF, 3'b011, 0);
        run_instr("mul",  8'h03, {3'd1,10'd20}, {3'd2,10'd21}, {3'd0,10'd0}, {3'd3,10'd22}, 4'd7,
                  32'h0001_0000, 32'h0001_0003, 32'd0, 1, 1, 0, 2, 0, 0, 1'b0,
                  32'h0003_0000, 3'b011, 0);
        run_instr("add3", 8'h05, {3'd1,10'd30}, {3'd2,10'd31}, {3'd3,10'd32}, {3'd4,10'd33}, 4'd9,
                  32'd1, 32'd2, 32'd3, 6, 7, 5, 0, 0, 0, 1'b0, 32'd6, 3'b111, 0);
        run_instr("copy", 8'h06, {3'd2,10'd40}, {3'd3,10'd41}, {3'd4,10'd42}, {3'd5,10'd43}, 4'd10,
                  32'hA5A5_0001, 32'd7, 32'd9, 2, 0, 0, 1, 0, 0, 1'b1, 32'hA5A5_0001, 3'b001, 0);
        run_instr("op7f", 8'h7F, {3'd6,10'd50}, {3'd1,10'd51}, {3'd2,10'd52}, {3'd0,10'd53}, 4'd11,
                  32'h1234_5678, 32'd7, 32'd9, 0, 0, 0, 0, 0, 0, 1'b1, 32'h1234_5678, 3'b001, 0);
        run_instr("bkpr", 8'h01, {3'd1,10'd60}, {3'd2,10'd61}, {3'd0,10'd0}, {3'd3,10'd62}, 4'd12,
                  32'h7FFF_FFFF, 32'd1, 32'd0, 1, 1, 0, 0, 4, 3, 1'b0, 32'h8000_0000, 3'b011, 0);
        run_instr("abort", 8'h01, {3'd1,10'd70}, {3'd2,10'd71}, {3'd0,10'd0}, {3'd3,10'd72}, 4'd13,
                  32'd4, 32'd4, 32'd0, 50, 50, 0, 10, 0, 0, 1'b0, 32'd8, 3'b011, 5);
        run_instr("post_abort", 8'h05, {3'd1,10'd80}, {3'd2,10'd81}, {3'd3,10'd82}, {3'd4,10'd83},
                  4'd14, 32'd10, 32'd20, 32'd30, 1, 2, 3, 0, 0, 0, 1'b0, 32'd60, 3'b111, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
